// File: rtl/ssram_block_reader_if.sv
// ssram_block_reader_if: command, SSRAM port-B and output-stream bundle for ssram_block_reader.
// Latency: none (wires only); abort exists only when SSRAM_BLOCK_READER_ABORT_EN is defined.
// Backpressure: streamReady from the consumer; master = block reader, slave = its environment.
interface ssram_block_reader_if #(
   parameter int bitwidth    = 32,
   parameter int nrOfEntries = 512
);
   localparam int AW = $clog2(nrOfEntries);

   logic                start;
   logic [AW-1:0]       startAddress;
   logic [AW:0]         blockSize;
   logic                busy;
   logic                done;
   logic [AW-1:0]       ramAddress;
   logic                ramWriteEnable;
   logic [bitwidth-1:0] ramDataOut;
   logic [bitwidth-1:0] streamData;
   logic                streamValid;
   logic                streamReady;

`ifdef SSRAM_BLOCK_READER_ABORT_EN
   logic                abort;

   modport master (
      input  start, startAddress, blockSize, ramDataOut, streamReady, abort,
      output busy, done, ramAddress, ramWriteEnable, streamData, streamValid
   );
   modport slave (
      output start, startAddress, blockSize, ramDataOut, streamReady, abort,
      input  busy, done, ramAddress, ramWriteEnable, streamData, streamValid
   );
`else
   modport master (
      input  start, startAddress, blockSize, ramDataOut, streamReady,
      output busy, done, ramAddress, ramWriteEnable, streamData, streamValid
   );
   modport slave (
      output start, startAddress, blockSize, ramDataOut, streamReady,
      input  busy, done, ramAddress, ramWriteEnable, streamData, streamValid
   );
`endif
endinterface

// File: rtl/ssram_block_reader.sv
// ssram_block_reader: streams a block of consecutive SSRAM port-B words on valid/ready (abort port with SSRAM_BLOCK_READER_ABORT_EN).
// Latency: start in cycle 0, ramAddress in cycle 1, first streamValid in cycle 3; then one word per cycle.
// Backpressure: reads issue only against free FIFO credit, so consumer stalls throttle issue and nothing drops.
module ssram_block_reader #(
   parameter int bitwidth    = 32,
   parameter int nrOfEntries = 512,
   parameter int fifoDepth   = 4
) (
   input  logic                 clock,
   input  logic                 nReset,
   ssram_block_reader_if.master bus
);
   localparam int AW = $clog2(nrOfEntries);
   localparam int PW = $clog2(fifoDepth);
   localparam int CW = PW + 1;
   localparam int OW = CW + 1;

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t              state_q;
   logic                busy_q;
   logic                done_q;
   logic                rd_vld_q;
   logic                dat_vld_q;
   logic [AW-1:0]       ram_addr_q;
   logic [AW-1:0]       next_addr_q;
   logic [AW:0]         remaining_q;

   logic [bitwidth-1:0] fifo_mem_q [fifoDepth];
   logic [PW-1:0]       wr_ptr_q;
   logic [PW-1:0]       rd_ptr_q;
   logic [CW-1:0]       fifo_cnt_q;

   logic                abort_req;
   logic                push;
   logic                pop;
   logic                credit_ok;
   logic                issue;
   logic                last_pop;
   logic [OW-1:0]       occupancy;

   function automatic logic [AW-1:0] inc_addr(input logic [AW-1:0] a);
      return (a == AW'(nrOfEntries - 1)) ? '0 : a + AW'(1);
   endfunction

`ifdef SSRAM_BLOCK_READER_ABORT_EN
   assign abort_req = bus.abort && busy_q;
`else
   assign abort_req = 1'b0;
`endif

   // Words in the FIFO plus reads whose data has not landed yet; pops are ignored to keep credit conservative.
   always_comb begin
      occupancy = OW'(fifo_cnt_q) + OW'(rd_vld_q) + OW'(dat_vld_q);
   end

   assign credit_ok = occupancy < OW'(fifoDepth);
   assign issue     = (state_q == READ) && (remaining_q != '0) && credit_ok && !abort_req;
   assign push      = dat_vld_q && !abort_req;
   assign pop       = (fifo_cnt_q != '0) && bus.streamReady;
   assign last_pop  = (state_q == DRAIN) && !rd_vld_q && !dat_vld_q &&
                      (fifo_cnt_q == CW'(1)) && pop && !abort_req;

   always_ff @(posedge clock) begin
      if (!nReset) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_vld_q    <= 1'b0;
         dat_vld_q   <= 1'b0;
         ram_addr_q  <= '0;
         next_addr_q <= '0;
         remaining_q <= '0;
      end else begin
         done_q    <= 1'b0;
         rd_vld_q  <= 1'b0;
         dat_vld_q <= rd_vld_q;
         if (abort_req) begin
            // Drop everything in flight; the word now on ramDataOut is never pushed.
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            dat_vld_q   <= 1'b0;
            remaining_q <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (bus.start) begin
                     if (bus.blockSize == '0) begin
                        done_q <= 1'b1;
                     end else begin
                        ram_addr_q  <= bus.startAddress;
                        next_addr_q <= inc_addr(bus.startAddress);
                        remaining_q <= bus.blockSize - (AW+1)'(1);
                        rd_vld_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= (bus.blockSize == (AW+1)'(1)) ? DRAIN : READ;
                     end
                  end
               end
               READ: begin
                  if (issue) begin
                     ram_addr_q  <= next_addr_q;
                     next_addr_q <= inc_addr(next_addr_q);
                     remaining_q <= remaining_q - (AW+1)'(1);
                     rd_vld_q    <= 1'b1;
                     if (remaining_q == (AW+1)'(1)) begin
                        state_q <= DRAIN;
                     end
                  end
               end
               DRAIN: begin
                  if (last_pop) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!nReset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         for (int i = 0; i < fifoDepth; i++) begin
            fifo_mem_q[i] <= '0;
         end
      end else if (abort_req) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push) begin
            fifo_mem_q[wr_ptr_q] <= bus.ramDataOut;
            wr_ptr_q             <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
      end
   end

   assign bus.busy           = busy_q;
   assign bus.done           = done_q | last_pop;
   assign bus.ramAddress     = ram_addr_q;
   assign bus.ramWriteEnable = 1'b0;
   assign bus.streamData     = fifo_mem_q[rd_ptr_q];
   assign bus.streamValid    = (fifo_cnt_q != '0);
endmodule

// File: tb/tb_ssram_block_reader.sv
// tb_ssram_block_reader: directed blocks with a scoreboard queue of expected words checked by a stream monitor.
module tb_ssram_block_reader;
   logic clock = 1'b0;
   logic nReset;

   ssram_block_reader_if #(.bitwidth(32), .nrOfEntries(512)) bus ();

   ssram_block_reader #(.bitwidth(32), .nrOfEntries(512), .fifoDepth(4)) dut (
      .clock  (clock),
      .nReset (nReset),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   logic [31:0] mem [512];
   always @(posedge clock) bus.ramDataOut <= mem[bus.ramAddress];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          rdy_mode = 0;
   int          acc_n = 0;
   int          last_acc_cyc = -1;
   int          first_vld_cyc = -1;
   int          done_cyc = -1;
   int          start_cyc = 0;
   bit          done_seen = 1'b0;
   logic [31:0] exp_q [$];
   logic        prev_vld = 1'b0;
   logic        prev_rdy = 1'b0;
   logic [31:0] prev_dat = '0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Consumer ready: 0 = always ready, 1 = pattern 1,0,0,1, otherwise stalled.
   initial begin
      bus.streamReady = 1'b0;
      forever begin
         @(posedge clock);
         #2;
         case (rdy_mode)
            0:       bus.streamReady = 1'b1;
            1:       bus.streamReady = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: bus.streamReady = 1'b0;
         endcase
      end
   end

   always @(negedge clock) begin
      if (bus.streamValid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (rdy_mode == 1) begin
         if (prev_vld && !prev_rdy) begin
            chk("stall_valid_hold", int'(bus.streamValid), 1);
            chk("stall_data_hold", int'(bus.streamData), int'(prev_dat));
         end
         chk("fifo_count_bound", int'(dut.fifo_cnt_q <= 4), 1);
      end
      if (bus.streamValid && bus.streamReady) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_word", int'(bus.streamData), -1);
         end else begin
            chk("stream_data", int'(bus.streamData), int'(exp_q.pop_front()));
         end
         acc_n++;
         last_acc_cyc = cyc;
      end
      if (bus.done) begin
         chk("done_with_words_pending", exp_q.size(), 0);
         done_seen = 1'b1;
         done_cyc  = cyc;
      end
      prev_vld = bus.streamValid;
      prev_rdy = bus.streamReady;
      prev_dat = bus.streamData;
   end

   task automatic start_block(input int addr, input int size);
      for (int k = 0; k < size; k++) exp_q.push_back(mem[(addr + k) % 512]);
      acc_n         = 0;
      done_seen     = 1'b0;
      first_vld_cyc = -1;
      @(posedge clock);
      #1;
      bus.start        = 1'b1;
      bus.startAddress = 9'(addr);
      bus.blockSize    = 10'(size);
      start_cyc        = cyc;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done_seen && n < budget) begin
         @(negedge clock);
         #1;
         n++;
      end
      chk("done_seen", int'(done_seen), 1);
   endtask

   task automatic wait_acc(input int want, input int budget);
      int n = 0;
      while (acc_n < want && n < budget) begin
         @(negedge clock);
         #1;
         n++;
      end
      chk("acc_reached", int'(acc_n >= want), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int ra;
      for (int k = 0; k < 512; k++) mem[k] = 32'(k + 32'h100);
      nReset           = 1'b0;
      bus.start        = 1'b0;
      bus.startAddress = '0;
      bus.blockSize    = '0;
`ifdef SSRAM_BLOCK_READER_ABORT_EN
      bus.abort = 1'b0;
`endif
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_valid", int'(bus.streamValid), 0);
      chk("rst_ramaddr", int'(bus.ramAddress), 0);
      chk("rst_we", int'(bus.ramWriteEnable), 0);
      chk("rst_data", int'(bus.streamData), 0);
      nReset = 1'b1;

      // Basic block with latency and done timing
      start_block(5, 4);
      @(negedge clock);
      chk("t1_addr_cycle1", int'(bus.ramAddress), 5);
      wait_done(100);
      chk("t1_first_valid_cycle", first_vld_cyc - start_cyc, 3);
      chk("t1_done_cycle", done_cyc - start_cyc, 6);
      chk("t1_done_at_last_acc", done_cyc, last_acc_cyc);
      chk("t1_count", acc_n, 4);
      @(negedge clock);
      chk("t1_busy_after_done", int'(bus.busy), 0);

      // Address wrap at the top of memory
      start_block(510, 4);
      @(negedge clock);
      chk("t2_addr_c1", int'(bus.ramAddress), 510);
      @(negedge clock);
      chk("t2_addr_c2", int'(bus.ramAddress), 511);
      @(negedge clock);
      chk("t2_addr_c3", int'(bus.ramAddress), 0);
      wait_done(100);
      chk("t2_count", acc_n, 4);

      // Backpressure pattern
      rdy_mode = 1;
      start_block(32, 16);
      wait_done(400);
      chk("t3_count", acc_n, 16);
      chk("t3_queue_empty", exp_q.size(), 0);
      rdy_mode = 0;

      // Zero-length block
      @(negedge clock);
      ra = int'(bus.ramAddress);
      start_block(7, 0);
      @(negedge clock);
      chk("t4_done", int'(bus.done), 1);
      chk("t4_busy", int'(bus.busy), 0);
      chk("t4_valid", int'(bus.streamValid), 0);
      chk("t4_addr_unchanged", int'(bus.ramAddress), ra);
      @(negedge clock);
      chk("t4_done_single", int'(bus.done), 0);
      chk("t4_busy_c2", int'(bus.busy), 0);

      // Reset in the middle of a transfer
      start_block(40, 8);
      wait_acc(2, 100);
      @(posedge clock);
      #1;
      nReset = 1'b0;
      @(posedge clock);
      #1;
      exp_q.delete();
      @(negedge clock);
      chk("t5_busy", int'(bus.busy), 0);
      chk("t5_valid", int'(bus.streamValid), 0);
      chk("t5_done", int'(bus.done), 0);
      nReset = 1'b1;
      start_block(100, 2);
      wait_done(100);
      chk("t5_count_after", acc_n, 2);
      chk("t5_queue_empty", exp_q.size(), 0);

      // start while busy is ignored
      start_block(20, 6);
      bus.start        = 1'b1;
      bus.startAddress = 9'd300;
      bus.blockSize    = 10'd3;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      wait_done(100);
      chk("t6_count", acc_n, 6);
      repeat (4) @(negedge clock);
      chk("t6_no_extra", acc_n, 6);
      chk("t6_idle", int'(bus.busy), 0);

`ifdef SSRAM_BLOCK_READER_ABORT_EN
      start_block(60, 10);
      wait_acc(3, 100);
      rdy_mode = 2;
      @(posedge clock);
      #1;
      bus.abort = 1'b1;
      exp_q.delete();
      @(posedge clock);
      #1;
      bus.abort = 1'b0;
      @(negedge clock);
      chk("t7_valid", int'(bus.streamValid), 0);
      chk("t7_done", int'(bus.done), 1);
      chk("t7_busy", int'(bus.busy), 0);
      chk("t7_addr", int'(bus.ramAddress), 65);
      rdy_mode = 0;
      repeat (3) begin
         @(negedge clock);
         chk("t7_addr_frozen", int'(bus.ramAddress), 65);
         chk("t7_valid_low", int'(bus.streamValid), 0);
      end
      chk("t7_acc", acc_n, 3);
      start_block(200, 3);
      wait_done(100);
      chk("t7_recover_count", acc_n, 3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
